// File: rtl/que_rd_unpack_if.sv
// Bundle of the queue-side and beat-stream-side signals of the read unpacker.
// master: the unpacker itself. slave: the environment (queue + downstream).
interface que_rd_unpack_if #(
  parameter int WD  = 32,
  parameter int OWD = 8
);
  logic [WD-1:0]  q_data;
  logic           q_empty;
  logic           q_pop;
  logic           flush;
  logic           m_valid;
  logic           m_ready;
  logic [OWD-1:0] m_data;
  logic           m_last;
  logic           busy;

  modport master (
    input  q_data, q_empty, flush, m_ready,
    output q_pop, m_valid, m_data, m_last, busy
  );

  modport slave (
    output q_data, q_empty, flush, m_ready,
    input  q_pop, m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/que_rd_unpack.sv
// Read-side unpacker: pops WD-bit words from the async queue and emits them
// as RATIO beats of OWD bits on a valid/ready stream, one beat per cycle.
//
// Handshake: a beat moves when m_valid & m_ready on a rising clk edge.
// m_valid is held with m_data/m_last stable until that transfer happens;
// only flush (or reset) may withdraw a valid beat.
module que_rd_unpack #(
  parameter int WD        = 32,
  parameter int OWD       = 8,
  parameter int LSB_FIRST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  que_rd_unpack_if.master bus
);
  localparam int RATIO = WD / OWD;
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(RATIO - 1);

  logic [WD-1:0] hold_q, hold_d;
  logic          hold_v_q, hold_v_d;
  logic [CW-1:0] beat_q, beat_d;

  logic          xfer;
  logic          take;
  logic          pop;
  logic [CW-1:0] sel;
  logic [WD-1:0] shifted;

  // Handshake terms; pop is gated by rst_n so nothing is requested while in reset.
  always_comb begin
    xfer = hold_v_q & bus.m_ready;
    take = xfer & (beat_q == LAST_BEAT);
    pop  = rst_n & ~bus.q_empty & ~bus.flush & (~hold_v_q | take);
  end

  // Beat selection from the held word only; no path from q_data to m_data.
  always_comb begin
    sel     = (LSB_FIRST != 0) ? beat_q : (LAST_BEAT - beat_q);
    shifted = hold_q >> (32'(sel) * OWD);
  end

  assign bus.q_pop   = pop;
  assign bus.m_valid = hold_v_q;
  assign bus.m_data  = shifted[OWD-1:0];
  assign bus.m_last  = hold_v_q & (beat_q == LAST_BEAT);
  assign bus.busy    = hold_v_q;

  // Next state: flush wins, then a pop reloads, then a final beat empties,
  // otherwise a transfer advances the beat position.
  always_comb begin
    hold_d   = hold_q;
    hold_v_d = hold_v_q;
    beat_d   = beat_q;
    if (bus.flush) begin
      hold_v_d = 1'b0;
      beat_d   = '0;
    end else if (pop) begin
      hold_d   = bus.q_data;
      hold_v_d = 1'b1;
      beat_d   = '0;
    end else if (take) begin
      hold_v_d = 1'b0;
      beat_d   = '0;
    end else if (xfer) begin
      beat_d   = beat_q + CW'(1);
    end
  end

  // State registers; an asynchronous reset drops the held word and position at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      hold_v_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      hold_q   <= hold_d;
      hold_v_q <= hold_v_d;
      beat_q   <= beat_d;
    end
  end

`ifndef SYNTHESIS
  a_no_pop_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.q_pop && bus.q_empty));
  a_data_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.m_valid && !bus.m_ready && !bus.flush) |=> $stable(bus.m_data));
  a_beat_range : assert property (@(posedge clk) disable iff (!rst_n)
    beat_q <= LAST_BEAT);
`endif
endmodule

// File: tb/tb_que_rd_unpack.sv
// Directed bench for que_rd_unpack: three instances (LSB-first bytes,
// MSB-first bytes, full-width pass-through), each fed by a small queue model.
module tb_que_rd_unpack;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  que_rd_unpack_if #(.WD(32), .OWD(8))  bus_a ();
  que_rd_unpack_if #(.WD(32), .OWD(8))  bus_b ();
  que_rd_unpack_if #(.WD(32), .OWD(32)) bus_c ();

  que_rd_unpack #(.WD(32), .OWD(8),  .LSB_FIRST(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  que_rd_unpack #(.WD(32), .OWD(8),  .LSB_FIRST(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  que_rd_unpack #(.WD(32), .OWD(32), .LSB_FIRST(1)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo_a[$];
  logic [31:0] fifo_b[$];
  logic [31:0] fifo_c[$];
  int pops_a = 0;
  int pops_b = 0;
  int pops_c = 0;

  // Queue models: head word and registered empty flag update after each pop.
  always @(posedge clk) begin
    if (rst_n && bus_a.q_pop && fifo_a.size() != 0) begin
      pops_a++;
      fifo_a.delete(0);
      bus_a.q_empty <= (fifo_a.size() == 0);
      bus_a.q_data  <= (fifo_a.size() != 0) ? fifo_a[0] : 32'h0;
    end
  end
  always @(posedge clk) begin
    if (rst_n && bus_b.q_pop && fifo_b.size() != 0) begin
      pops_b++;
      fifo_b.delete(0);
      bus_b.q_empty <= (fifo_b.size() == 0);
      bus_b.q_data  <= (fifo_b.size() != 0) ? fifo_b[0] : 32'h0;
    end
  end
  always @(posedge clk) begin
    if (rst_n && bus_c.q_pop && fifo_c.size() != 0) begin
      pops_c++;
      fifo_c.delete(0);
      bus_c.q_empty <= (fifo_c.size() == 0);
      bus_c.q_data  <= (fifo_c.size() != 0) ? fifo_c[0] : 32'h0;
    end
  end

  task automatic push_a(input logic [31:0] w);
    fifo_a.push_back(w);
    bus_a.q_empty <= 1'b0;
    bus_a.q_data  <= fifo_a[0];
  endtask
  task automatic push_b(input logic [31:0] w);
    fifo_b.push_back(w);
    bus_b.q_empty <= 1'b0;
    bus_b.q_data  <= fifo_b[0];
  endtask
  task automatic push_c(input logic [31:0] w);
    fifo_c.push_back(w);
    bus_c.q_empty <= 1'b0;
    bus_c.q_data  <= fifo_c[0];
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %b want 0", bus_a.m_valid); end
    checks++; if (bus_a.m_last !== 1'b0) begin errors++; $display("FAIL rst_a_last got %b want 0", bus_a.m_last); end
    checks++; if (bus_a.q_pop !== 1'b0) begin errors++; $display("FAIL rst_a_pop got %b want 0", bus_a.q_pop); end
    checks++; if (bus_a.busy !== 1'b0) begin errors++; $display("FAIL rst_a_busy got %b want 0", bus_a.busy); end
    checks++; if (bus_a.m_data !== 8'h00) begin errors++; $display("FAIL rst_a_data got %h want 00", bus_a.m_data); end
    checks++; if (bus_b.m_valid !== 1'b0) begin errors++; $display("FAIL rst_b_valid got %b want 0", bus_b.m_valid); end
    checks++; if (bus_c.m_valid !== 1'b0) begin errors++; $display("FAIL rst_c_valid got %b want 0", bus_c.m_valid); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.m_valid !== 1'b0 || bus_a.q_pop !== 1'b0) begin
      errors++; $display("FAIL idle_a got valid=%b pop=%b want 0 0", bus_a.m_valid, bus_a.q_pop);
    end
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int base = pops_a;
    @(posedge clk); #1;
    push_a(32'h44332211);
    @(negedge clk);
    checks++; if (bus_a.q_pop !== 1'b1) begin errors++; $display("FAIL single_pop got %b want 1", bus_a.q_pop); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp[i] || bus_a.m_last !== (i == 3) || bus_a.q_pop !== 1'b0) begin
        errors++; $display("FAIL single_beat%0d got v=%b d=%h l=%b p=%b want 1 %h %b 0", i, bus_a.m_valid, bus_a.m_data, bus_a.m_last, bus_a.q_pop, exp[i], (i == 3));
      end
    end
    @(negedge clk);
    checks++; if (bus_a.m_valid !== 1'b0 || bus_a.busy !== 1'b0) begin errors++; $display("FAIL single_end got v=%b busy=%b want 0 0", bus_a.m_valid, bus_a.busy); end
    checks++; if (pops_a - base !== 1) begin errors++; $display("FAIL single_popcnt got %0d want 1", pops_a - base); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w [3] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0};
    logic [31:0] cur;
    logic [7:0]  e;
    int base = pops_a;
    @(posedge clk); #1;
    push_a(w[0]); push_a(w[1]); push_a(w[2]);
    @(negedge clk);
    checks++; if (bus_a.q_pop !== 1'b1) begin errors++; $display("FAIL stream_pop0 got %b want 1", bus_a.q_pop); end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      cur = w[i / 4];
      e = cur[8 * (i % 4) +: 8];
      checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== e || bus_a.m_last !== ((i % 4) == 3)
                    || bus_a.q_pop !== (((i % 4) == 3) && (i < 11))) begin
        errors++; $display("FAIL stream_beat%0d got v=%b d=%h l=%b p=%b want 1 %h %b %b", i, bus_a.m_valid, bus_a.m_data,
                           bus_a.m_last, bus_a.q_pop, e, ((i % 4) == 3), (((i % 4) == 3) && (i < 11)));
      end
    end
    @(negedge clk);
    checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL stream_end got %b want 0", bus_a.m_valid); end
    checks++; if (pops_a - base !== 3) begin errors++; $display("FAIL stream_popcnt got %0d want 3", pops_a - base); end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    push_a(32'h44332211);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_a.m_data !== 8'h11) begin errors++; $display("FAIL bp_b0 got %h want 11", bus_a.m_data); end
    @(negedge clk);
    checks++; if (bus_a.m_data !== 8'h22) begin errors++; $display("FAIL bp_b1 got %h want 22", bus_a.m_data); end
    @(negedge clk);
    checks++; if (bus_a.m_data !== 8'h33) begin errors++; $display("FAIL bp_b2 got %h want 33", bus_a.m_data); end
    bus_a.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== 8'h33 || bus_a.q_pop !== 1'b0 || bus_a.m_last !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got v=%b d=%h p=%b l=%b want 1 33 0 0", i, bus_a.m_valid, bus_a.m_data, bus_a.q_pop, bus_a.m_last);
      end
    end
    bus_a.m_ready = 1'b1;
    @(negedge clk);
    checks++; if (bus_a.m_data !== 8'h44 || bus_a.m_last !== 1'b1) begin errors++; $display("FAIL bp_b3 got %h l=%b want 44 1", bus_a.m_data, bus_a.m_last); end
    @(negedge clk);
    checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL bp_end got %b want 0", bus_a.m_valid); end
  endtask

  task automatic test_msb_first();
    logic [7:0] exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    @(posedge clk); #1;
    push_b(32'h44332211);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_b.m_valid !== 1'b1 || bus_b.m_data !== exp[i] || bus_b.m_last !== (i == 3)) begin
        errors++; $display("FAIL msb_beat%0d got v=%b d=%h l=%b want 1 %h %b", i, bus_b.m_valid, bus_b.m_data, bus_b.m_last, exp[i], (i == 3));
      end
    end
    @(negedge clk);
    checks++; if (bus_b.m_valid !== 1'b0) begin errors++; $display("FAIL msb_end got %b want 0", bus_b.m_valid); end
  endtask

  task automatic test_ratio1();
    logic [31:0] w [4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
    int base = pops_c;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) push_c(w[i]);
    @(negedge clk);
    checks++; if (bus_c.q_pop !== 1'b1 || bus_c.m_valid !== 1'b0) begin errors++; $display("FAIL r1_start got p=%b v=%b want 1 0", bus_c.q_pop, bus_c.m_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_c.m_valid !== 1'b1 || bus_c.m_data !== w[i] || bus_c.m_last !== 1'b1 || bus_c.q_pop !== (i < 3)) begin
        errors++; $display("FAIL r1_beat%0d got v=%b d=%h l=%b p=%b want 1 %h 1 %b", i, bus_c.m_valid, bus_c.m_data, bus_c.m_last, bus_c.q_pop, w[i], (i < 3));
      end
    end
    @(negedge clk);
    checks++; if (bus_c.m_valid !== 1'b0) begin errors++; $display("FAIL r1_end got %b want 0", bus_c.m_valid); end
    checks++; if (pops_c - base !== 4) begin errors++; $display("FAIL r1_popcnt got %0d want 4", pops_c - base); end
  endtask

  task automatic test_flush();
    logic [7:0] exp [4] = '{8'h55, 8'h66, 8'h77, 8'h88};
    @(posedge clk); #1;
    push_a(32'h44332211); push_a(32'h88776655);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_a.m_data !== 8'h11) begin errors++; $display("FAIL fl_b0 got %h want 11", bus_a.m_data); end
    @(negedge clk);
    checks++; if (bus_a.m_data !== 8'h22) begin errors++; $display("FAIL fl_b1 got %h want 22", bus_a.m_data); end
    bus_a.flush = 1'b1;
    #1;
    checks++; if (bus_a.q_pop !== 1'b0) begin errors++; $display("FAIL fl_pop_b1 got %b want 0", bus_a.q_pop); end
    @(negedge clk);
    checks++; if (bus_a.m_valid !== 1'b0 || bus_a.busy !== 1'b0 || bus_a.q_pop !== 1'b0) begin
      errors++; $display("FAIL fl_cycle got v=%b busy=%b p=%b want 0 0 0", bus_a.m_valid, bus_a.busy, bus_a.q_pop);
    end
    bus_a.flush = 1'b0;
    #1;
    checks++; if (bus_a.q_pop !== 1'b1) begin errors++; $display("FAIL fl_resume got %b want 1", bus_a.q_pop); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp[i] || bus_a.m_last !== (i == 3)) begin
        errors++; $display("FAIL fl_beat%0d got v=%b d=%h l=%b want 1 %h %b", i, bus_a.m_valid, bus_a.m_data, bus_a.m_last, exp[i], (i == 3));
      end
    end
    @(negedge clk);
    checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL fl_end got %b want 0", bus_a.m_valid); end
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [4] = '{8'h0A, 8'h0B, 8'h0C, 8'h0D};
    @(posedge clk); #1;
    push_a(32'h44332211); push_a(32'h0D0C0B0A);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus_a.m_data !== 8'h33) begin errors++; $display("FAIL mr_b2 got %h want 33", bus_a.m_data); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_a.m_valid !== 1'b0 || bus_a.q_pop !== 1'b0 || bus_a.m_last !== 1'b0 || bus_a.busy !== 1'b0) begin
      errors++; $display("FAIL mr_async got v=%b p=%b l=%b busy=%b want 0 0 0 0", bus_a.m_valid, bus_a.q_pop, bus_a.m_last, bus_a.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (bus_a.q_pop !== 1'b1 || bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL mr_release got p=%b v=%b want 1 0", bus_a.q_pop, bus_a.m_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus_a.m_valid !== 1'b1 || bus_a.m_data !== exp[i] || bus_a.m_last !== (i == 3)) begin
        errors++; $display("FAIL mr_beat%0d got v=%b d=%h l=%b want 1 %h %b", i, bus_a.m_valid, bus_a.m_data, bus_a.m_last, exp[i], (i == 3));
      end
    end
    @(negedge clk);
    checks++; if (bus_a.m_valid !== 1'b0) begin errors++; $display("FAIL mr_end got %b want 0", bus_a.m_valid); end
  endtask

  initial begin
    bus_a.q_empty = 1'b1; bus_a.q_data = '0; bus_a.flush = 1'b0; bus_a.m_ready = 1'b1;
    bus_b.q_empty = 1'b1; bus_b.q_data = '0; bus_b.flush = 1'b0; bus_b.m_ready = 1'b1;
    bus_c.q_empty = 1'b1; bus_c.q_data = '0; bus_c.flush = 1'b0; bus_c.m_ready = 1'b1;
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_msb_first();
    test_ratio1();
    test_flush();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
